// File: rtl/car_motion_ctrl.sv
// car_motion_ctrl: once per frame, during vertical blanking, steps the car sprite origin
// using the gamepad levels. Holding a direction accelerates the step, and the origin is clamped to the screen.
// Latency: a tick in cycle T gives SAMPLE in T+1, the new cars_x in T+3, the new cars_y plus an update_done pulse in T+4.
module car_motion_ctrl #(
   parameter int SCREEN_W     = 640,
   parameter int SCREEN_H     = 480,
   parameter int SPRITE_W     = 272,
   parameter int SPRITE_H     = 138,
   parameter int INIT_X       = 184,
   parameter int INIT_Y       = 171,
   parameter int MAX_STEP     = 8,
   parameter int ACCEL_FRAMES = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [9:0] x,
   input  logic [8:0] y,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       freeze,
   output logic [9:0] cars_x,
   output logic [8:0] cars_y,
   output logic [3:0] step,
   output logic       update_done
);

   typedef enum logic [2:0] {IDLE, SAMPLE, MOVE_X, MOVE_Y, DONE} state_t;

   localparam logic signed [10:0] X_MAX    = 11'(SCREEN_W - SPRITE_W);
   localparam logic signed [10:0] Y_MAX    = 11'(SCREEN_H - SPRITE_H);
   localparam logic [3:0]         STEP_MAX = 4'(MAX_STEP);
   localparam logic [8:0]         ACCEL_N  = 9'(ACCEL_FRAMES);
   localparam logic [9:0]         X0       = 10'(INIT_X);
   localparam logic [8:0]         Y0       = 9'(INIT_Y);
   localparam logic [8:0]         VB_LINE  = 9'(SCREEN_H);

   state_t            state;
   logic              vb, vb_q, tick;
   logic              dx_pos, dx_neg, dy_pos, dy_neg;
   logic [7:0]        hold;
   logic [8:0]        hold_inc;
   logic              axis_active;
   logic signed [10:0] step_s, nx, ny;
   logic [9:0]        x_next;
   logic [8:0]        y_next;

   // The first pixel of the first blanking line marks the frame. The edge detect keeps it to one cycle when the pixel clock is slower than CLK.
   assign vb   = (y == VB_LINE) && (x == 10'd0);
   assign tick = vb && !vb_q;

   // Register vb so that the tick is produced only on its rising edge.
   always_ff @(posedge CLK) begin
      if (RST) vb_q <= 1'b0;
      else     vb_q <= vb;
   end

   // Next-origin arithmetic is signed, so that a step past zero can be detected and saturated instead of wrapping.
   always_comb begin
      axis_active = (btn_right ^ btn_left) | (btn_down ^ btn_up);
      hold_inc    = {1'b0, hold} + 9'd1;
      step_s      = $signed({7'd0, step});
      nx          = $signed({1'b0, cars_x});
      ny          = $signed({2'b00, cars_y});
      if (dx_pos)      nx = nx + step_s;
      else if (dx_neg) nx = nx - step_s;
      if (dy_pos)      ny = ny + step_s;
      else if (dy_neg) ny = ny - step_s;
      x_next = nx[9:0];
      if (nx < 11'sd0)      x_next = 10'd0;
      else if (nx > X_MAX)  x_next = X_MAX[9:0];
      y_next = ny[8:0];
      if (ny < 11'sd0)      y_next = 9'd0;
      else if (ny > Y_MAX)  y_next = Y_MAX[8:0];
   end

   // Frame update sequencer. Buttons are looked at only in SAMPLE, and each axis is written in its own state.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= IDLE;
         cars_x      <= X0;
         cars_y      <= Y0;
         step        <= 4'd1;
         update_done <= 1'b0;
         hold        <= 8'd0;
         dx_pos      <= 1'b0;
         dx_neg      <= 1'b0;
         dy_pos      <= 1'b0;
         dy_neg      <= 1'b0;
      end else begin
         update_done <= 1'b0;
         case (state)
            IDLE: begin
               if (tick && !freeze) state <= SAMPLE;
            end
            SAMPLE: begin
               // Opposing buttons cancel on their axis.
               dx_pos <= btn_right & ~btn_left;
               dx_neg <= btn_left  & ~btn_right;
               dy_pos <= btn_down  & ~btn_up;
               dy_neg <= btn_up    & ~btn_down;
               if (axis_active) begin
                  if (hold_inc == ACCEL_N) begin
                     hold <= 8'd0;
                     if (step < STEP_MAX) step <= step + 4'd1;
                  end else begin
                     hold <= hold_inc[7:0];
                  end
               end else begin
                  hold <= 8'd0;
                  step <= 4'd1;
               end
               state <= MOVE_X;
            end
            MOVE_X: begin
               cars_x <= x_next;
               state  <= MOVE_Y;
            end
            MOVE_Y: begin
               cars_y      <= y_next;
               update_done <= 1'b1;
               state       <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_car_motion_ctrl.sv
// Directed bench for car_motion_ctrl. Frames are produced by driving the blanking pixel for one cycle,
// and the origin, step and update_done are checked at their cycle-exact visibility points.
module tb_car_motion_ctrl;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [9:0] x = 10'd1;
   logic [8:0] y = 9'd0;
   logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
   logic       freeze = 1'b0;
   logic [9:0] cars_x;
   logic [8:0] cars_y;
   logic [3:0] step;
   logic       update_done;

   int total = 0;
   int bad = 0;
   int pulses = 0;
   int ex, ey, estep, ehold;
   int saved;

   car_motion_ctrl #(
      .SCREEN_W(640), .SCREEN_H(480), .SPRITE_W(272), .SPRITE_H(138),
      .INIT_X(184), .INIT_Y(171), .MAX_STEP(8), .ACCEL_FRAMES(8)
   ) dut (
      .CLK(CLK), .RST(RST), .x(x), .y(y),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
      .freeze(freeze), .cars_x(cars_x), .cars_y(cars_y), .step(step),
      .update_done(update_done)
   );

   always #5 CLK = ~CLK;

   // Count update_done pulses, sampling away from the active edge.
   always @(negedge CLK) if (update_done === 1'b1) pulses++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int clampi(input int v, input int hi);
      if (v < 0) return 0;
      if (v > hi) return hi;
      return v;
   endfunction

   // One blanking tick in cycle T. The new x is checked at T+3, and the new y, step and done pulse at T+4.
   task automatic frame(input int exp_x, input int exp_y, input int exp_step, input logic exp_done);
      @(negedge CLK); x = 10'd0; y = 9'd480;   // T
      @(negedge CLK); x = 10'd1; y = 9'd0;     // T+1
      @(negedge CLK);                          // T+2
      chk("done_early", 32'(update_done), 32'd0);
      @(negedge CLK);                          // T+3
      chk("cars_x", 32'(cars_x), exp_x);
      @(negedge CLK);                          // T+4
      chk("cars_y", 32'(cars_y), exp_y);
      chk("step", 32'(step), exp_step);
      chk("update_done", 32'(update_done), 32'(exp_done));
      @(negedge CLK);                          // back in IDLE
   endtask

   // Behavioural reference for one unfrozen frame with the given buttons.
   task automatic mframe(input logic u, input logic d, input logic l, input logic r);
      int dx, dy;
      btn_up = u; btn_down = d; btn_left = l; btn_right = r;
      dx = int'(r && !l) - int'(l && !r);
      dy = int'(d && !u) - int'(u && !d);
      if (dx != 0 || dy != 0) begin
         ehold++;
         if (ehold == 8) begin
            ehold = 0;
            if (estep < 8) estep++;
         end
      end else begin
         ehold = 0;
         estep = 1;
      end
      ex = clampi(ex + dx * estep, 368);
      ey = clampi(ey + dy * estep, 342);
      frame(ex, ey, estep, 1'b1);
   endtask

   initial begin
      ex = 184; ey = 171; estep = 1; ehold = 0;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      chk("rst_x", 32'(cars_x), 32'd184);
      chk("rst_y", 32'(cars_y), 32'd171);
      chk("rst_step", 32'(step), 32'd1);
      chk("rst_done", 32'(update_done), 32'd0);

      // Idle frames: the origin holds and each frame pulses update_done once.
      for (int i = 0; i < 3; i++) mframe(0, 0, 0, 0);
      chk("idle_pulses", pulses, 32'd3);

      // Hold right: acceleration every 8 frames, saturating at 8, with x clamped at 368.
      for (int i = 1; i <= 56; i++) begin
         mframe(0, 0, 0, 1);
         if (i == 7) chk("step_f7", 32'(step), 32'd1);
         if (i == 8) chk("step_f8", 32'(step), 32'd2);
      end
      chk("right_step_sat", 32'(step), 32'd8);
      chk("right_x_clamp", 32'(cars_x), 32'd368);

      // Drive y down to 3 and build the step up to 4, then press up into the top edge.
      mframe(0, 0, 0, 0);
      for (int i = 0; i < 47; i++) mframe(1, 0, 0, 0);
      mframe(0, 0, 0, 0);
      mframe(1, 0, 0, 0);
      for (int i = 0; i < 23; i++) mframe(0, 0, 0, 1);
      chk("pre_up_y", 32'(cars_y), 32'd3);
      chk("pre_up_step", 32'(step), 32'd4);
      mframe(1, 0, 0, 0);
      chk("up_clamp_y", 32'(cars_y), 32'd0);
      mframe(1, 0, 0, 0);
      chk("up_stay_y", 32'(cars_y), 32'd0);

      // Left and right cancel each other while down moves one pixel per frame.
      mframe(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) mframe(0, 1, 1, 1);
      chk("lr_x", 32'(cars_x), 32'd368);
      chk("lr_y", 32'(cars_y), 32'd3);

      // Frozen ticks are ignored entirely, and the first tick after release moves the sprite.
      saved = pulses;
      freeze = 1'b1; btn_down = 1'b1; btn_left = 1'b0; btn_right = 1'b0; btn_up = 1'b0;
      frame(ex, ey, estep, 1'b0);
      frame(ex, ey, estep, 1'b0);
      chk("freeze_pulses", pulses, saved);
      freeze = 1'b0;
      mframe(0, 1, 0, 0);
      chk("unfreeze_y", 32'(cars_y), 32'd4);

      // A reset during MOVE_X aborts the update and reloads the initial origin.
      saved = pulses;
      btn_down = 1'b1; btn_up = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
      @(negedge CLK); x = 10'd0; y = 9'd480;   // T
      @(negedge CLK); x = 10'd1; y = 9'd0;     // T+1 SAMPLE
      @(negedge CLK); RST = 1'b1;              // T+2
      @(negedge CLK); RST = 1'b0;
      chk("abort_x", 32'(cars_x), 32'd184);
      chk("abort_y", 32'(cars_y), 32'd171);
      chk("abort_step", 32'(step), 32'd1);
      repeat (4) @(negedge CLK);
      chk("abort_no_done", pulses, saved);
      ex = 184; ey = 171; estep = 1; ehold = 0;
      mframe(0, 1, 0, 0);
      chk("post_abort_y", 32'(cars_y), 32'd172);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
